// File: rtl/param_data_ram_pkg.sv
// -----------------------------------------------------------------------------
// param_ram_pkg
// Shared constants and helpers for the parametrised data RAM block.
//   DEF_*      : default parameter values used by the interface and top.
//   clog2()    : ceiling log2, usable in constant expressions.
//   be_width() : number of byte lanes for a given data width.
// The pipeline stage record {valid, data} depends on DATA_W, so the top
// declares it next to the parameter that sizes it.
// -----------------------------------------------------------------------------
package param_ram_pkg;

  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_ADDR_W       = 8;
  localparam int unsigned DEF_READ_LATENCY = 2;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/param_data_ram_if.sv
// -----------------------------------------------------------------------------
// param_data_ram_if
// Request/response channel of the parametrised data RAM.
//   req_valid/req_ready : request handshake (accept when both high)
//   req_wren            : 1 = write, 0 = read
//   req_addr            : word address
//   req_data/req_be     : write data and per-byte enables
//   rsp_valid/rsp_ready : response handshake (pop when both high)
//   rsp_data            : read data, head of the response FIFO
//   busy                : at least one read in the pipeline or FIFO
// master = requester/consumer side, slave = RAM side.
// -----------------------------------------------------------------------------
interface param_data_ram_if
  import param_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  localparam int unsigned BE_W = be_width(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    output req_valid, req_wren, req_addr, req_data, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_wren, req_addr, req_data, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/param_data_ram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// param_ram_rsp_fifo
// First-word-fall-through response FIFO.
//   clk, reset   : clock, async active-high reset (pointers/count only)
//   i_push       : write i_push_data at the tail
//   i_pop        : remove the head (ignored when empty)
//   o_valid      : count != 0
//   o_head       : head entry, zero while empty
//   o_count      : occupancy, one bit wider than the pointers
// Pointers wrap modulo FIFO_DEPTH, so non power-of-two depths also work.
// -----------------------------------------------------------------------------
module param_ram_rsp_fifo
  import param_ram_pkg::*;
#(
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? clog2(FIFO_DEPTH) : 1,
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_store [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop   = i_pop && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_store[r_rptr] : '0;
  assign o_count = r_count;

  // Storage carries no reset; stale entries are hidden by the count.
  always_ff @(posedge clk) begin
    if (i_push) r_store[r_wptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    i_push |-> (r_count != CNT_W'(FIFO_DEPTH)));

endmodule

// File: rtl/param_data_ram.sv
// -----------------------------------------------------------------------------
// param_data_ram
// Parametrised single-port synchronous data memory with byte-enable writes,
// a valid/ready request channel, fixed read latency and a credit-guarded
// first-word-fall-through response FIFO.
//   clk   : system clock, rising edge
//   reset : async active-high; clears control state, memory survives
//   bus   : param_data_ram_if.slave (request, response, busy)
// A read samples mem at its accepting edge, travels READ_LATENCY-1 further
// register stages and is pushed into the FIFO READ_LATENCY edges later.
// -----------------------------------------------------------------------------
module param_data_ram
  import param_ram_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  param_data_ram_if.slave    bus
);

  localparam int unsigned BE_W  = be_width(DATA_W);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CRD_W = clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  stage_t            r_pipe [READ_LATENCY];
  logic [CRD_W-1:0]  r_credit;

  logic              w_req_ready;
  logic              w_wr_accept;
  logic              w_rd_accept;
  logic              w_pop;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] w_rsp_data;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [31:0]       w_occupancy;

  // Writes are gated by credit too, so a write can never overtake a read
  // that is still waiting for FIFO space.
  assign w_req_ready = (r_credit != '0);
  assign w_wr_accept = bus.req_valid && w_req_ready && bus.req_wren;
  assign w_rd_accept = bus.req_valid && w_req_ready && !bus.req_wren;
  assign w_pop       = w_rsp_valid && bus.rsp_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = w_rsp_data;
  assign bus.busy      = (r_credit != CRD_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) r_mem[bus.req_addr][8*i +: 8] <= bus.req_data[8*i +: 8];
      end
    end
  end

  // Only one request is accepted per edge, so the sampled word never
  // collides with a write; a write on the previous edge is already visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0].valid <= w_rd_accept;
      if (w_rd_accept) r_pipe[0].data <= r_mem[bus.req_addr];
      for (int unsigned i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit <= CRD_W'(FIFO_DEPTH);
    end else begin
      case ({w_rd_accept, w_pop})
        2'b10:   r_credit <= r_credit - CRD_W'(1);
        2'b01:   r_credit <= r_credit + CRD_W'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  param_ram_rsp_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_pipe[READ_LATENCY-1].valid),
    .i_push_data (r_pipe[READ_LATENCY-1].data),
    .i_pop       (w_pop),
    .o_valid     (w_rsp_valid),
    .o_head      (w_rsp_data),
    .o_count     (w_fifo_count)
  );

  always_comb begin
    w_occupancy = 32'(w_fifo_count);
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      w_occupancy = w_occupancy + 32'(r_pipe[i].valid);
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    r_credit <= CRD_W'(FIFO_DEPTH));

  a_credit_balance: assert property (@(posedge clk) disable iff (reset)
    (32'(r_credit) + w_occupancy) == 32'(FIFO_DEPTH));

  a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
    (w_rsp_valid && !bus.rsp_ready) |=> $stable(w_rsp_data));

endmodule

// File: tb/tb_param_data_ram.sv
module tb_param_data_ram;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  param_data_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  param_data_ram #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .READ_LATENCY (LAT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: a plain word array plus the queue of responses owed, in order.
  logic [31:0] model [256];
  logic [31:0] exp_q [$];

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The word visible before the edge is the one popped at that edge.
  task automatic tick();
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_spurious", 64'(bus.rsp_valid), 64'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("rsp_data", 64'(bus.rsp_data), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (n == 64) check("req_ready_timeout", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_wren  = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_be    = be;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    bus.req_wren  = 1'b0;
    model_write(a, d, be);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] expected);
    bus.req_valid = 1'b1;
    bus.req_wren  = 1'b0;
    bus.req_addr  = a;
    wait_ready();
    exp_q.push_back(expected);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 32) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          acc;
    int          drops;
    logic [7:0]  a;
    logic [7:0]  ra;
    logic        b1, b2, b3;

    bus.req_valid = 1'b0;
    bus.req_wren  = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    reset = 1'b0;
    tick();
    tick();

    // Basic write then read, with exact latency.
    wr(8'h10, 32'hDEADBEEF, 4'hF);
    rd(8'h10, 32'hDEADBEEF);
    check("t1_valid_e0", 64'(bus.rsp_valid), 64'd0);
    check("t1_busy_e0",  64'(bus.busy),      64'd1);
    tick();
    check("t1_valid_e1", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("t1_valid_e2", 64'(bus.rsp_valid), 64'd1);
    check("t1_data_e2",  64'(bus.rsp_data),  64'hDEADBEEF);
    tick();
    check("t1_valid_after_pop", 64'(bus.rsp_valid), 64'd0);
    check("t1_busy_after_pop",  64'(bus.busy),      64'd0);

    // Byte-enable merge.
    wr(8'h05, 32'h11223344, 4'hF);
    wr(8'h05, 32'hAABBCCDD, 4'b0101);
    rd(8'h05, 32'h11BB33DD);
    drain();

    // Backpressure: only FIFO_DEPTH reads get credit.
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      ra = (acc % 2 == 1) ? 8'h05 : 8'h10;
      bus.req_valid = 1'b1;
      bus.req_wren  = 1'b0;
      bus.req_addr  = ra;
      if (bus.req_ready === 1'b1) begin
        acc++;
        exp_q.push_back(model[ra]);
      end
      tick();
    end
    bus.req_valid = 1'b0;
    check("t3_accepted", 64'(acc), 64'(FD));
    check("t3_ready_low", 64'(bus.req_ready), 64'd0);
    check("t3_busy", 64'(bus.busy), 64'd1);
    tick();
    tick();
    check("t3_head_stalled", 64'(bus.rsp_data), 64'(exp_q[0]));
    bus.rsp_ready = 1'b1;
    check("t3_ready_before_pop", 64'(bus.req_ready), 64'd0);
    tick();
    check("t3_ready_after_pop", 64'(bus.req_ready), 64'd1);
    drain();

    // Read immediately after write to the same address.
    wr(8'h20, 32'hCAFEF00D, 4'hF);
    bus.req_valid = 1'b1;
    bus.req_wren  = 1'b1;
    bus.req_addr  = 8'h20;
    bus.req_data  = 32'h00000001;
    bus.req_be    = 4'hF;
    check("t4_ready_wr", 64'(bus.req_ready), 64'd1);
    tick();
    model_write(8'h20, 32'h00000001, 4'hF);
    bus.req_wren = 1'b0;
    exp_q.push_back(32'h00000001);
    check("t4_ready_rd", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    drain();

    // Reset with reads in flight.
    bus.rsp_ready = 1'b0;
    rd(8'h10, 32'hDEADBEEF);
    rd(8'h05, model[8'h05]);
    tick();
    tick();
    check("t5_valid_before_rst", 64'(bus.rsp_valid), 64'd1);
    check("t5_busy_before_rst",  64'(bus.busy),      64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_valid_async", 64'(bus.rsp_valid), 64'd0);
    check("t5_busy_async",  64'(bus.busy),      64'd0);
    check("t5_ready_async", 64'(bus.req_ready), 64'd1);
    check("t5_data_async",  64'(bus.rsp_data),  64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (6) tick();
    check("t5_no_stale", 64'(bus.rsp_valid), 64'd0);
    rd(8'h10, 32'hDEADBEEF);
    drain();

    // Randomised fill, partial overwrites, then a 256-read stream.
    for (int i = 0; i < 256; i++) wr(8'(i), $urandom, 4'hF);
    for (int i = 0; i < 64; i++) wr(8'($urandom_range(0, 255)), $urandom, 4'($urandom));
    drops = 0;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      bus.req_valid = 1'b1;
      bus.req_wren  = 1'b0;
      bus.req_addr  = a;
      if (bus.req_ready !== 1'b1) drops++;
      wait_ready();
      exp_q.push_back(model[a]);
      tick();
    end
    bus.req_valid = 1'b0;
    check("t6_ready_never_dropped", 64'(drops), 64'd0);
    tick();
    b1 = bus.busy;
    tick();
    b2 = bus.busy;
    tick();
    b3 = bus.busy;
    check("t6_busy_e1", 64'(b1), 64'd1);
    check("t6_busy_e2", 64'(b2), 64'd1);
    check("t6_busy_e3", 64'(b3), 64'd0);
    check("t6_all_rsp", 64'(exp_q.size()), 64'd0);
    check("t6_rsp_idle", 64'(bus.rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
